// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler: round-robin arbitration of two writeback
// requesters onto the single write port, a registered output stage, and a
// busy-register scoreboard that drives the read-stall signal.
// Optional feature macro: REGFILE_SCHED_FWD_EN adds Fwd1/Fwd2 bypass outputs
// and removes the stall for a source being written in the current cycle.
module regfile_write_scheduler #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ReqA_valid,
  output logic                ReqA_ready,
  input  logic [ADDR_W-1:0]   ReqA_reg,
  input  logic [DATA_W-1:0]   ReqA_data,
  input  logic                ReqB_valid,
  output logic                ReqB_ready,
  input  logic [ADDR_W-1:0]   ReqB_reg,
  input  logic [DATA_W-1:0]   ReqB_data,
  input  logic                Reserve_valid,
  input  logic [ADDR_W-1:0]   Reserve_reg,
  input  logic [ADDR_W-1:0]   ReadReg1,
  input  logic [ADDR_W-1:0]   ReadReg2,
  output logic                Stall,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteReg,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] Busy
`ifdef REGFILE_SCHED_FWD_EN
  ,
  output logic                Fwd1,
  output logic                Fwd2
`endif
);

  // prio_q = 0 prefers A on contention, 1 prefers B.
  logic                prio_q, prio_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic hs_a;
  logic hs_b;
  logic src1_pend;
  logic src2_pend;

  // Round-robin ready generation; at most one handshake per cycle.
  always_comb begin
    ReqA_ready = ~(ReqB_valid & prio_q);
    ReqB_ready = ~(ReqA_valid & ~prio_q);
    hs_a       = ReqA_valid & ReqA_ready;
    hs_b       = ReqB_valid & ReqB_ready;
  end

  // Next-state: priority flip, output-stage load, scoreboard update.
  always_comb begin
    prio_d       = prio_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;

    // Contention hands priority to the requester that just lost.
    if (ReqA_valid && ReqB_valid) begin
      prio_d = ~prio_q;
    end

    // Writes to register 0 are accepted but never enable the port.
    if (hs_a) begin
      write_reg_d  = ReqA_reg;
      write_data_d = ReqA_data;
      reg_write_d  = (ReqA_reg != '0);
    end else if (hs_b) begin
      write_reg_d  = ReqB_reg;
      write_data_d = ReqB_data;
      reg_write_d  = (ReqB_reg != '0);
    end

    // Commit clears first so a same-edge reserve of that register wins.
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (Reserve_valid) begin
      busy_d[Reserve_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      prio_q       <= prio_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  // Source-pending detection for the two read ports.
  always_comb begin
    src1_pend = busy_q[ReadReg1] & (ReadReg1 != '0);
    src2_pend = busy_q[ReadReg2] & (ReadReg2 != '0);
  end

`ifdef REGFILE_SCHED_FWD_EN
  // Bypass the value being committed this cycle instead of stalling on it.
  always_comb begin
    Fwd1  = reg_write_q & (write_reg_q != '0) & (write_reg_q == ReadReg1);
    Fwd2  = reg_write_q & (write_reg_q != '0) & (write_reg_q == ReadReg2);
    Stall = (src1_pend & ~Fwd1) | (src2_pend & ~Fwd2);
  end
`else
  // Stall while any non-zero source register is still pending.
  always_comb begin
    Stall = src1_pend | src2_pend;
  end
`endif

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed vector table for
// the multi-cycle scenarios, then randomized traffic against a reference model.
module tb_regfile_write_scheduler;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned RAND_CYCLES = 3000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ReqA_valid, ReqA_ready;
  logic [ADDR_W-1:0]   ReqA_reg;
  logic [DATA_W-1:0]   ReqA_data;
  logic                ReqB_valid, ReqB_ready;
  logic [ADDR_W-1:0]   ReqB_reg;
  logic [DATA_W-1:0]   ReqB_data;
  logic                Reserve_valid;
  logic [ADDR_W-1:0]   Reserve_reg;
  logic [ADDR_W-1:0]   ReadReg1, ReadReg2;
  logic                Stall;
  logic                RegWrite;
  logic [ADDR_W-1:0]   WriteReg;
  logic [DATA_W-1:0]   WriteData;
  logic [NUM_REGS-1:0] Busy;
`ifdef REGFILE_SCHED_FWD_EN
  logic                Fwd1, Fwd2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ReqA_valid   (ReqA_valid),
    .ReqA_ready   (ReqA_ready),
    .ReqA_reg     (ReqA_reg),
    .ReqA_data    (ReqA_data),
    .ReqB_valid   (ReqB_valid),
    .ReqB_ready   (ReqB_ready),
    .ReqB_reg     (ReqB_reg),
    .ReqB_data    (ReqB_data),
    .Reserve_valid(Reserve_valid),
    .Reserve_reg  (Reserve_reg),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .Stall        (Stall),
    .RegWrite     (RegWrite),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .Busy         (Busy)
`ifdef REGFILE_SCHED_FWD_EN
    ,
    .Fwd1         (Fwd1),
    .Fwd2         (Fwd2)
`endif
  );

  // One directed cycle: inputs applied for the cycle, outputs expected in it.
  typedef struct {
    logic              rst;
    logic              av;
    logic [ADDR_W-1:0] areg;
    logic [DATA_W-1:0] adata;
    logic              bv;
    logic [ADDR_W-1:0] breg;
    logic [DATA_W-1:0] bdata;
    logic              rv;
    logic [ADDR_W-1:0] rreg;
    logic [ADDR_W-1:0] rd1;
    logic [ADDR_W-1:0] rd2;
    logic              chk;
    logic              rw;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic [NUM_REGS-1:0] busy;
    logic              ra;
    logic              rb;
    logic              stall;
    logic              stall_fwd;
    logic              fwd1;
    logic              fwd2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic av, input int areg, input int adata,
    input logic bv, input int breg, input int bdata,
    input logic rv, input int rreg, input int rd1, input int rd2,
    input logic chk, input logic rw, input int wreg, input int wdata,
    input int busy, input logic ra, input logic rb,
    input logic stall, input logic stall_fwd, input logic fwd1, input logic fwd2);
    vec_t v;
    v.rst = rst; v.av = av; v.areg = ADDR_W'(areg); v.adata = DATA_W'(adata);
    v.bv = bv; v.breg = ADDR_W'(breg); v.bdata = DATA_W'(bdata);
    v.rv = rv; v.rreg = ADDR_W'(rreg); v.rd1 = ADDR_W'(rd1); v.rd2 = ADDR_W'(rd2);
    v.chk = chk; v.rw = rw; v.wreg = ADDR_W'(wreg); v.wdata = DATA_W'(wdata);
    v.busy = NUM_REGS'(busy); v.ra = ra; v.rb = rb;
    v.stall = stall; v.stall_fwd = stall_fwd; v.fwd1 = fwd1; v.fwd2 = fwd2;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Reference model state (values visible during the current cycle).
  bit              m_pref_b;
  bit              m_rw;
  int              m_wreg;
  logic [DATA_W-1:0] m_wdata;
  bit              m_busy[NUM_REGS];

  task automatic model_reset();
    m_pref_b = 1'b0;
    m_rw     = 1'b0;
    m_wreg   = 0;
    m_wdata  = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
  endtask

  function automatic logic [NUM_REGS-1:0] model_busy_vec();
    logic [NUM_REGS-1:0] v;
    for (int i = 0; i < int'(NUM_REGS); i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit model_fwd(input int r);
`ifdef REGFILE_SCHED_FWD_EN
    return m_rw && (r != 0) && (m_wreg == r);
`else
    return (r < 0);
`endif
  endfunction

  function automatic bit model_pending(input int r);
    return (r != 0) && m_busy[r] && !model_fwd(r);
  endfunction

  task automatic drive_idle();
    ReqA_valid = 1'b0; ReqA_reg = '0; ReqA_data = '0;
    ReqB_valid = 1'b0; ReqB_reg = '0; ReqB_data = '0;
    Reserve_valid = 1'b0; Reserve_reg = '0;
    ReadReg1 = '0; ReadReg2 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // Directed scenarios, one row per clock cycle.
    //            rst av ar ad   bv br bd  rv rr r1 r2  chk rw wr wd  busy ra rb st sf f1 f2
    vecs.push_back(mk(0, 0,0,0,   0,0,0,  0,0,0,0,   0, 0,0,0,  0,   0,0, 0,0,0,0));
    vecs.push_back(mk(0, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,0,0,  0,   1,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,0,0,  0,   1,1, 0,0,0,0));
    vecs.push_back(mk(1, 1,1,37,  0,0,0,  0,0,0,0,   1, 0,0,0,  0,   1,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 1,1,37, 0,   1,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,1,37, 0,   1,1, 0,0,0,0));
    // Contention: grants alternate A,B,A,B.
    vecs.push_back(mk(1, 1,2,5,   1,3,9,  0,0,0,0,   1, 0,1,37, 0,   1,0, 0,0,0,0));
    vecs.push_back(mk(1, 1,2,5,   1,3,9,  0,0,0,0,   1, 1,2,5,  0,   0,1, 0,0,0,0));
    vecs.push_back(mk(1, 1,2,5,   1,3,9,  0,0,0,0,   1, 1,3,9,  0,   1,0, 0,0,0,0));
    vecs.push_back(mk(1, 1,2,5,   1,3,9,  0,0,0,0,   1, 1,2,5,  0,   0,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 1,3,9,  0,   1,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,3,9,  0,   1,1, 0,0,0,0));
    // Scoreboard: reserve reg 4, stall until N+2 after its handshake.
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  1,4,4,0,   1, 0,3,9,  0,   1,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,4,0,   1, 0,3,9,  'h10,1,1, 1,1,0,0));
    vecs.push_back(mk(1, 1,4,'h44,0,0,0,  0,0,4,0,   1, 0,3,9,  'h10,1,0, 1,1,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,4,0,   1, 1,4,'h44,'h10,1,1, 1,0,1,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,4,0,   1, 0,4,'h44,0,  1,1, 0,0,0,0));
    // Commit and reserve of reg 6 at the same edge: reserve wins.
    vecs.push_back(mk(1, 1,6,'h66,0,0,0,  1,6,0,0,   1, 0,4,'h44,0,  1,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  1,6,0,6,   1, 1,6,'h66,'h40,1,1, 1,0,0,1));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,6,   1, 0,6,'h66,'h40,1,1, 1,1,0,0));
    vecs.push_back(mk(1, 1,6,'h67,0,0,0,  0,0,0,0,   1, 0,6,'h66,'h40,1,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 1,6,'h67,'h40,1,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,6,'h67,0,  1,1, 0,0,0,0));
    // Register 0: accepted, never written, never reserved, never stalls.
    vecs.push_back(mk(1, 0,0,0,   1,0,-1, 1,0,0,0,   1, 0,6,'h67,0,  1,1, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,0,-1, 0,   1,1, 0,0,0,0));
    // Reg 7 written while read: stall without bypass, Fwd2 with it.
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  1,7,0,0,   1, 0,0,-1, 0,   1,1, 0,0,0,0));
    vecs.push_back(mk(1, 1,7,'h77,0,0,0,  0,0,0,0,   1, 0,0,-1, 'h80,1,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,7,   1, 1,7,'h77,'h80,1,1, 1,0,0,1));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,7,   1, 0,7,'h77,0,  1,1, 0,0,0,0));
    // Reset with a handshake at the same edge discards the write.
    vecs.push_back(mk(0, 1,5,'h55,0,0,0,  1,9,0,0,   1, 0,7,'h77,0,  1,0, 0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,   0,0,0,  0,0,0,0,   1, 0,0,0,  0,   1,1, 0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n         = vecs[i].rst;
      ReqA_valid    = vecs[i].av;
      ReqA_reg      = vecs[i].areg;
      ReqA_data     = vecs[i].adata;
      ReqB_valid    = vecs[i].bv;
      ReqB_reg      = vecs[i].breg;
      ReqB_data     = vecs[i].bdata;
      Reserve_valid = vecs[i].rv;
      Reserve_reg   = vecs[i].rreg;
      ReadReg1      = vecs[i].rd1;
      ReadReg2      = vecs[i].rd2;
      #1;
      if (vecs[i].chk) begin
        cmp("vec_RegWrite",   i, 32'(RegWrite),   32'(vecs[i].rw));
        cmp("vec_WriteReg",   i, 32'(WriteReg),   32'(vecs[i].wreg));
        cmp("vec_WriteData",  i, 32'(WriteData),  32'(vecs[i].wdata));
        cmp("vec_Busy",       i, 32'(Busy),       32'(vecs[i].busy));
        cmp("vec_ReqA_ready", i, 32'(ReqA_ready), 32'(vecs[i].ra));
        cmp("vec_ReqB_ready", i, 32'(ReqB_ready), 32'(vecs[i].rb));
`ifdef REGFILE_SCHED_FWD_EN
        cmp("vec_Stall",      i, 32'(Stall),      32'(vecs[i].stall_fwd));
        cmp("vec_Fwd1",       i, 32'(Fwd1),       32'(vecs[i].fwd1));
        cmp("vec_Fwd2",       i, 32'(Fwd2),       32'(vecs[i].fwd2));
`else
        cmp("vec_Stall",      i, 32'(Stall),      32'(vecs[i].stall));
`endif
      end
    end

    // Randomized traffic against the reference model; first cycle is reset.
    model_reset();
    for (int c = 0; c < int'(RAND_CYCLES); c++) begin
      bit win_a;
      bit win_b;
      int ar;
      int br;
      int rr;
      @(negedge clk);
      rst_n         = (c == 0) ? 1'b0 : ($urandom_range(63) != 0);
      ReqA_valid    = 1'($urandom_range(1));
      ReqB_valid    = 1'($urandom_range(1));
      Reserve_valid = 1'($urandom_range(1));
      ReqA_reg      = ADDR_W'(($urandom_range(3) == 0) ? $urandom_range(NUM_REGS-1) : $urandom_range(7));
      ReqB_reg      = ADDR_W'(($urandom_range(3) == 0) ? $urandom_range(NUM_REGS-1) : $urandom_range(7));
      Reserve_reg   = ADDR_W'(($urandom_range(3) == 0) ? $urandom_range(NUM_REGS-1) : $urandom_range(7));
      ReadReg1      = ADDR_W'($urandom_range(7));
      ReadReg2      = ADDR_W'($urandom_range(7));
      ReqA_data     = DATA_W'($urandom);
      ReqB_data     = DATA_W'($urandom);
      #1;

      // Winner: the only valid requester, or the preferred one on contention.
      win_a = ReqA_valid && (!ReqB_valid || !m_pref_b);
      win_b = ReqB_valid && (!ReqA_valid || m_pref_b);

      cmp("rnd_ReqA_ready", c, 32'(ReqA_ready), 32'(!(ReqB_valid && m_pref_b)));
      cmp("rnd_ReqB_ready", c, 32'(ReqB_ready), 32'(!(ReqA_valid && !m_pref_b)));
      cmp("rnd_RegWrite",   c, 32'(RegWrite),   32'(m_rw));
      cmp("rnd_WriteReg",   c, 32'(WriteReg),   32'(m_wreg));
      cmp("rnd_WriteData",  c, 32'(WriteData),  32'(m_wdata));
      cmp("rnd_Busy",       c, 32'(Busy),       32'(model_busy_vec()));
      cmp("rnd_Stall",      c, 32'(Stall),
          32'(model_pending(int'(ReadReg1)) || model_pending(int'(ReadReg2))));
`ifdef REGFILE_SCHED_FWD_EN
      cmp("rnd_Fwd1",       c, 32'(Fwd1),       32'(model_fwd(int'(ReadReg1))));
      cmp("rnd_Fwd2",       c, 32'(Fwd2),       32'(model_fwd(int'(ReadReg2))));
`endif

      // Advance the model to the values visible after this edge.
      ar = int'(ReqA_reg);
      br = int'(ReqB_reg);
      rr = int'(Reserve_reg);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (m_rw) m_busy[m_wreg] = 1'b0;
        if (Reserve_valid && rr != 0) m_busy[rr] = 1'b1;
        if (win_a) begin
          m_wreg = ar; m_wdata = ReqA_data; m_rw = (ar != 0);
        end else if (win_b) begin
          m_wreg = br; m_wdata = ReqB_data; m_rw = (br != 0);
        end else begin
          m_rw = 1'b0;
        end
        if (ReqA_valid && ReqB_valid) m_pref_b = !m_pref_b;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register file; arbitrates two writeback requesters (A = ALU result, B = memory load) onto it with round-robin fairness.
- Keeps a busy-register scoreboard. Issue logic reserves destinations; readers of a pending register are stalled until the value is committed.
- Sits between the execute/memory writeback paths and the register file's WriteReg/WriteData/RegWrite inputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, register count (must equal 2**ADDR_W).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active low.
- ReqA_valid  input  1  requester A has a write pending.
- ReqA_ready  output  1  requester A is granted this cycle.
- ReqA_reg  input  ADDR_W  destination register of A.
- ReqA_data  input  DATA_W  write data of A.
- ReqB_valid, ReqB_ready, ReqB_reg, ReqB_data  same as A, for requester B.
- Reserve_valid  input  1  issue stage marks a destination as pending.
- Reserve_reg  input  ADDR_W  register to reserve.
- ReadReg1, ReadReg2  input  ADDR_W  registers being read this cycle.
- Stall  output  1  a read source is pending.
- RegWrite  output  1  register-file write enable (registered).
- WriteReg  output  ADDR_W  register-file write address (registered).
- WriteData  output  DATA_W  register-file write data (registered).
- Busy  output  NUM_REGS  scoreboard bits; bit i = register i pending.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge:
  - RegWrite, WriteReg and WriteData are cleared to 0.
  - Busy is cleared to all 0.
  - Priority pointer prio is set to 0 (A preferred).
- Reset mid-operation: an output-stage write loaded in the previous cycle is discarded, so RegWrite=0 in the cycle after reset.
- Arbitration (combinational ready):
  - ReqA_ready = ~(ReqB_valid & prio).
  - ReqB_ready = ~(ReqA_valid & ~prio).
  - A handshake is valid & ready. At most one handshake occurs per cycle.
  - When both valid are high at an edge, prio flips to point at the loser.
  - With one or no requester valid, prio holds.
- Output stage, 1-cycle latency: a handshake in cycle N loads WriteReg/WriteData at the edge ending cycle N.
  - RegWrite=1 during cycle N+1 and the register file commits at the edge ending N+1.
  - Without a handshake, RegWrite=0 next cycle; WriteReg/WriteData hold their values.
- Register 0:
  - A handshake with reg=0 is accepted (ready and prio behave normally), but RegWrite stays 0.
  - Reserve of reg 0 is ignored; Busy[0] is constant 0.
- Scoreboard:
  - Reserve_valid sets Busy[Reserve_reg] at the edge.
  - An output-stage commit (RegWrite=1) clears Busy[WriteReg] at the same edge the register file writes.
  - Reserve and clear of the same register at the same edge: the reserve wins (bit stays 1, new producer).
  - Reserving an already-busy register keeps it 1. There is one bit per register, no count; issue must not reserve a busy register.
- Stall = (Busy[ReadReg1] & ReadReg1!=0) | (Busy[ReadReg2] & ReadReg2!=0), combinational.
- Earliest unstall: a reader of register r is unstalled in cycle N+2 after a handshake for r in cycle N.
- Back-to-back handshakes are sustained, one per cycle; the output stage never blocks.

Optional Feature:
- Macro: REGFILE_SCHED_FWD_EN.
- Defined:
  - Adds outputs Fwd1 and Fwd2 (1 bit each). FwdX = RegWrite & WriteReg!=0 & WriteReg==ReadRegX.
  - Stall ignores a source whose FwdX=1. The datapath muxes WriteData in for that source.
  - Readers unstall in cycle N+1 instead of N+2.
- Undefined: no Fwd ports; Stall is exactly as in Behaviour.

Test Plan:
- Reset, then one write: rst_n=0 for 2 cycles, then 1 → RegWrite=0, Busy=0, Stall=0. Then ReqA valid with reg=1, data=37 → RegWrite=1, WriteReg=1, WriteData=37 exactly one cycle later.
- Contention: A (reg=2, data=5) and B (reg=3, data=9) both held valid for 4 cycles → grants alternate A, B, A, B. Output sequence is 5, 9, 5, 9.
- Scoreboard: reserve reg 4 → Busy[4]=1. ReadReg1=4 → Stall=1 until the cycle after RegWrite with WriteReg=4 (cycle N+2 from the handshake), then Stall=0.
- Simultaneous events: commit of reg 6 and Reserve_reg=6 at the same edge → Busy[6] stays 1.
- Register 0: ReqB reg=0, data=0xFFFFFFFF → ReqB_ready=1 and RegWrite stays 0. Reserve reg 0 → Busy[0]=0 and ReadReg1=0 never stalls.
- Forwarding build: with REGFILE_SCHED_FWD_EN and reg 7 written, ReadReg2=7 in the RegWrite cycle → Fwd2=1, Stall=0. Without the macro → Stall=1 in that cycle.
